// File: rtl/rrat_free_list.sv
// Retirement RAT plus the circular physical-register free list used for rename recovery.
// Define FREELIST_CHECK_EN to build the sticky err protocol checker and its assertions.
module rrat_free_list #(
   parameter int PHYS_REG_BITS = 6,
   parameter int FREE_DEPTH    = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        commit_valid,
   input  logic [4:0]                  commit_rd,
   input  logic [PHYS_REG_BITS-1:0]    commit_pd,
   input  logic                        dequeue,
   output logic [PHYS_REG_BITS-1:0]    free_pd,
   output logic                        free_empty,
   output logic [PHYS_REG_BITS-1:0]    free_count,
   input  logic                        flush,
   output logic [32*PHYS_REG_BITS-1:0] rrat_map,
   output logic                        err
);
   localparam int PTR_W = $clog2(FREE_DEPTH);
   localparam logic [PHYS_REG_BITS-1:0] FULL = PHYS_REG_BITS'(FREE_DEPTH);

   logic [PHYS_REG_BITS-1:0] rrat [32];
   logic [PHYS_REG_BITS-1:0] mem  [FREE_DEPTH];
   logic [PTR_W-1:0]         head;
   logic [PTR_W-1:0]         tail;
   logic [PTR_W-1:0]         tail_next;
   logic [PHYS_REG_BITS-1:0] count;
   logic [PHYS_REG_BITS-1:0] old_pd;
   logic                     enq;
   logic                     deq;

   assign enq        = commit_valid && (commit_rd != 5'd0);
   // A dequeue is dropped when the list is empty (even with a same-cycle commit) or on flush.
   assign deq        = dequeue && (count != '0) && !flush;
   assign old_pd     = rrat[commit_rd];
   assign tail_next  = enq ? tail + 1'b1 : tail;
   assign free_pd    = mem[head];
   assign free_empty = (count == '0);
   assign free_count = count;

   // Bypass the same-cycle commit so the front-end RAT can copy the map in the flush cycle.
   always_comb begin
      for (int i = 0; i < 32; i++) begin
         if (enq && (commit_rd == 5'(i)))
            rrat_map[i*PHYS_REG_BITS +: PHYS_REG_BITS] = commit_pd;
         else
            rrat_map[i*PHYS_REG_BITS +: PHYS_REG_BITS] = rrat[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++)
            rrat[i] <= PHYS_REG_BITS'(i);
         for (int k = 0; k < FREE_DEPTH; k++)
            mem[k] <= PHYS_REG_BITS'(32 + k);
         head  <= '0;
         tail  <= '0;
         count <= FULL;
      end else begin
         if (enq) begin
            rrat[commit_rd] <= commit_pd;
            mem[tail]       <= old_pd;
         end
         tail <= tail_next;
         // Flush rewinds: everything between tail and head is speculative and returns to the list.
         if (flush) begin
            head  <= tail_next;
            count <= FULL;
         end else begin
            if (deq)
               head <= head + 1'b1;
            case ({enq, deq})
               2'b10:   count <= (count == FULL) ? FULL : count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: ;
            endcase
         end
      end
   end

`ifdef FREELIST_CHECK_EN
   logic viol_empty;
   logic viol_full;
   logic viol_pd;
   logic err_q;

   assign viol_empty = dequeue && free_empty;
   assign viol_full  = enq && (count == FULL) && !dequeue;
   // Commit and allocation are both in program order, so the retiring tag must sit at tail.
   assign viol_pd    = enq && (commit_pd != mem[tail]);

   always_ff @(posedge clk) begin
      if (!rst)
         err_q <= 1'b0;
      else if (viol_empty || viol_full || viol_pd)
         err_q <= 1'b1;
   end

   assign err = err_q;

   a_deq_empty: assert property (@(posedge clk) disable iff (!rst) !viol_empty)
      else $warning("free list: dequeue while empty");
   a_enq_full: assert property (@(posedge clk) disable iff (!rst) !viol_full)
      else $warning("free list: enqueue while full");
   a_commit_pd: assert property (@(posedge clk) disable iff (!rst) !viol_pd)
      else $warning("free list: commit_pd differs from tail entry");
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rrat_free_list.sv
// Bench for rrat_free_list: queue-based reference model checked every cycle, plus literal checks.
module tb_rrat_free_list;
   localparam int PB = 6;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            commit_valid = 1'b0;
   logic [4:0]      commit_rd = '0;
   logic [PB-1:0]   commit_pd = '0;
   logic            dequeue = 1'b0;
   logic            flush = 1'b0;
   logic [PB-1:0]   free_pd;
   logic            free_empty;
   logic [PB-1:0]   free_count;
   logic [32*PB-1:0] rrat_map;
   logic            err;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model: arch->phys map, free registers in pop order, allocated-but-uncommitted in age order.
   int m_rrat [32];
   int free_q [$];
   int infl_q [$];
   bit m_err;

   always #5 clk = ~clk;

   rrat_free_list #(.PHYS_REG_BITS(PB), .FREE_DEPTH(32)) dut (
      .clk(clk), .rst(rst),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_pd(commit_pd),
      .dequeue(dequeue), .free_pd(free_pd), .free_empty(free_empty),
      .free_count(free_count), .flush(flush), .rrat_map(rrat_map), .err(err)
   );

   function automatic int map_at(int i);
      return int'(rrat_map[i*PB +: PB]);
   endfunction

   task automatic chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_vec(string name, logic [32*PB-1:0] act, logic [32*PB-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rrat[i] = i;
      free_q.delete();
      infl_q.delete();
      for (int k = 0; k < 32; k++) free_q.push_back(32 + k);
      m_err = 1'b0;
   endtask

   task automatic check_cycle();
      logic [32*PB-1:0] exp_map;
      for (int i = 0; i < 32; i++) exp_map[i*PB +: PB] = PB'(m_rrat[i]);
      if (commit_valid && commit_rd != 5'd0) exp_map[int'(commit_rd)*PB +: PB] = commit_pd;
      chk("free_count", int'(free_count), free_q.size());
      chk("free_empty", int'(free_empty), int'(free_q.size() == 0));
      if (free_q.size() != 0) chk("free_pd", int'(free_pd), free_q[0]);
      chk("err", int'(err), int'(m_err));
      chk_vec("rrat_map", rrat_map, exp_map);
   endtask

   task automatic model_update(bit cv, logic [4:0] rd, logic [PB-1:0] pd, bit dq, bit fl);
      bit deq_ok;
      int old;
      int tail_pd;
      deq_ok = dq && (free_q.size() != 0) && !fl;
`ifdef FREELIST_CHECK_EN
      tail_pd = (infl_q.size() != 0) ? infl_q[0] : free_q[0];
      if (dq && free_q.size() == 0) m_err = 1'b1;
      if (cv && rd != 0 && free_q.size() == 32 && !dq) m_err = 1'b1;
      if (cv && rd != 0 && int'(pd) != tail_pd) m_err = 1'b1;
`else
      tail_pd = 0;
`endif
      if (cv && rd != 0) begin
         old = m_rrat[rd];
         m_rrat[rd] = int'(pd);
         if (infl_q.size() != 0) void'(infl_q.pop_front());
         free_q.push_back(old);
      end
      if (deq_ok) infl_q.push_back(free_q.pop_front());
      if (fl) begin
         free_q = {infl_q, free_q};
         infl_q.delete();
      end
   endtask

   task automatic step(bit cv, logic [4:0] rd, logic [PB-1:0] pd, bit dq, bit fl);
      commit_valid = cv; commit_rd = rd; commit_pd = pd; dequeue = dq; flush = fl;
      #1;
      check_cycle();
      @(posedge clk);
      model_update(cv, rd, pd, dq, fl);
      #1;
      commit_valid = 1'b0; commit_rd = '0; commit_pd = '0; dequeue = 1'b0; flush = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      commit_valid = 1'b0; dequeue = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   task automatic deq_n(int n);
      for (int i = 0; i < n; i++) step(1'b0, 5'd0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      // Reset state
      do_reset();
      for (int i = 0; i < 32; i++) chk("reset_map", map_at(i), i);
      chk("reset_free_pd", int'(free_pd), 32);
      chk("reset_count", int'(free_count), 32);
      chk("reset_empty", int'(free_empty), 0);
      chk("reset_err", int'(err), 0);
      step(1'b0, 5'd0, '0, 1'b0, 1'b0);

      // Dequeue four, commit rd=5
      deq_n(4);
      step(1'b1, 5'd5, 6'd32, 1'b0, 1'b0);
      chk("commit_map5", map_at(5), 32);
      chk("commit_count", int'(free_count), 29);
      chk("commit_free_pd", int'(free_pd), 36);
      step(1'b0, 5'd0, '0, 1'b0, 1'b0);

      // Exhaust, then one extra dequeue
      do_reset();
      deq_n(32);
      chk("exhaust_empty", int'(free_empty), 1);
      chk("exhaust_count", int'(free_count), 0);
      step(1'b0, 5'd0, '0, 1'b1, 1'b0);
      chk("extra_count", int'(free_count), 0);
      chk("extra_free_pd", int'(free_pd), 32);
`ifdef FREELIST_CHECK_EN
      chk("extra_err", int'(err), 1);
`else
      chk("extra_err", int'(err), 0);
`endif
      step(1'b0, 5'd0, '0, 1'b0, 1'b0);

      // Simultaneous commit and dequeue
      do_reset();
      deq_n(1);
      step(1'b1, 5'd3, 6'd32, 1'b1, 1'b0);
      chk("simul_count", int'(free_count), 31);
      chk("simul_map3", map_at(3), 32);
      chk("simul_free_pd", int'(free_pd), 34);

      // Flush after a commit; register 1 lands at the back of the rewound list
      do_reset();
      deq_n(4);
      step(1'b1, 5'd1, 6'd32, 1'b0, 1'b0);
      step(1'b0, 5'd0, '0, 1'b0, 1'b1);
      chk("flush_count", int'(free_count), 32);
      chk("flush_free_pd", int'(free_pd), 33);
      chk("flush_map1", map_at(1), 32);
      deq_n(31);
      chk("flush_slot0", int'(free_pd), 1);
      step(1'b0, 5'd0, '0, 1'b0, 1'b0);

      // Flush with same-cycle commit; bypassed map visible in that cycle
      do_reset();
      deq_n(2);
      step(1'b1, 5'd1, 6'd32, 1'b0, 1'b0);
      commit_valid = 1'b1; commit_rd = 5'd2; commit_pd = 6'd33; flush = 1'b1;
      #1;
      chk("flushc_bypass_map2", map_at(2), 33);
      step(1'b1, 5'd2, 6'd33, 1'b0, 1'b1);
      chk("flushc_count", int'(free_count), 32);
      chk("flushc_free_pd", int'(free_pd), 34);

      // Commit to r0 changes nothing
      step(1'b1, 5'd0, 6'd17, 1'b0, 1'b0);
      chk("r0_map0", map_at(0), 0);
      chk("r0_count", int'(free_count), 32);
      chk("r0_free_pd", int'(free_pd), 34);
      step(1'b0, 5'd0, '0, 1'b0, 1'b0);

      // Randomized legal traffic with occasional flushes and empty-list dequeues
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bit cv;
         bit dq;
         bit fl;
         logic [4:0] rd;
         logic [PB-1:0] pd;
         dq = ($urandom_range(99) < 55);
         fl = ($urandom_range(99) < 3);
         cv = 1'b0; rd = '0; pd = '0;
         if ($urandom_range(99) < 50) begin
            rd = 5'($urandom_range(31));
            cv = 1'b1;
            if (rd == 5'd0) pd = PB'($urandom);
            else if (infl_q.size() != 0) pd = PB'(infl_q[0]);
            else cv = 1'b0;
         end
         step(cv, rd, pd, dq, fl);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/rrat_free_list.md
Name: rrat_free_list

Overview:
- Commit-side counterpart of the speculative rename table: the retirement RAT (RRAT) plus the physical-register free list.
- ROB commit writes arch->phys mappings here and releases superseded physical registers.
- Dispatch pops free physical registers from here.
- On flush, the front-end RAT reloads from rrat_map and the free list rewinds to the architectural state.

Parameters:
- PHYS_REG_BITS, 6, width of a physical register tag; NUM_PHYS = 2**PHYS_REG_BITS.
- FREE_DEPTH, 32, free-list slots; must equal NUM_PHYS-32.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low (asserted when 0)
- commit_valid  in  1  ROB head retires an instruction with register write
- commit_rd  in  5  architectural destination of retiring instruction
- commit_pd  in  PHYS_REG_BITS  physical destination of retiring instruction
- dequeue  in  1  dispatch consumes free_pd this cycle
- free_pd  out  PHYS_REG_BITS  free-list head entry
- free_empty  out  1  free list holds no entries
- free_count  out  PHYS_REG_BITS  number of valid free entries, 0..FREE_DEPTH
- flush  in  1  mispredict/exception recovery
- rrat_map  out  32*PHYS_REG_BITS  flattened RRAT, arch i at bits [i*PHYS_REG_BITS +: PHYS_REG_BITS]
- err  out  1  sticky protocol-violation flag (see Optional Feature)

Behaviour:
- State:
  - rrat[32]
  - mem[FREE_DEPTH] circular buffer
  - head, tail pointers (log2 FREE_DEPTH bits, natural wrap)
  - count
- Reset (rst==0 at clk edge):
  - rrat[i]=i; mem[k]=32+k; head=0, tail=0, count=FREE_DEPTH.
  - Outputs after reset: free_pd=32, free_empty=0, free_count=32, err=0.
- free_pd = mem[head]; free_empty = (count==0); both combinational from registered state.
- Commit (commit_valid && commit_rd!=0):
  - old = rrat[commit_rd]; rrat[commit_rd]<=commit_pd.
  - mem[tail]<=old; tail<=tail+1; count +1.
- Commit with commit_rd==0: no state change.
- Dequeue (dequeue && !free_empty): head<=head+1; count -1.
- Dequeue while empty: ignored; pointers and count unchanged.
- Commit + dequeue in the same cycle: both applied; count unchanged.
  - When count==0, the dequeue is still ignored, even if a commit enqueues that cycle.
- Invariant relied on by flush:
  - Allocation and commit are both in program order, so mem[tail] always equals commit_pd at commit.
  - The buffer therefore always holds exactly the NUM_PHYS-32 registers not in rrat.
- Flush:
  - The commit in the flush cycle is applied first (it is older than the flush).
  - Then head<=tail_next (tail after any commit) and count<=FREE_DEPTH.
  - A dequeue in the flush cycle is ignored.
- rrat_map is bypassed: it reflects rrat including a same-cycle commit, so the RAT may copy it in the flush cycle.
- Enqueue when count==FREE_DEPTH cannot occur legally; the enqueue still executes and count saturates at FREE_DEPTH.
- Latency:
  - A dequeued entry's successor is visible on free_pd the next cycle.
  - A released register is dequeuable the next cycle.

Optional Feature:
- Macro: FREELIST_CHECK_EN.
- When defined, err is set sticky (cleared only by reset) on any of:
  - dequeue while free_empty;
  - commit enqueue while count==FREE_DEPTH without a same-cycle dequeue;
  - commit with commit_rd!=0 and commit_pd != mem[tail].
- The same three conditions are also covered by simulation assertions.
- When undefined, err is tied to 0 and no check logic or assertions are built.

Test Plan:
- Reset: hold rst=0 two cycles, release -> rrat_map[i]=i for all i, free_pd=32, free_count=32, free_empty=0, err=0.
- Dequeue x4 (takes 32..35), then commit rd=5 pd=32 -> rrat_map[5]=32, mem[0]=5, free_count=29, free_pd=36.
- Exhaust: 32 consecutive dequeues -> free_empty=1, free_count=0; extra dequeue -> free_pd and count unchanged, err=1 with FREELIST_CHECK_EN, err=0 without.
- Simultaneous: after reset dequeue 32; next cycle commit rd=3 pd=32 plus dequeue -> free_count stays 31, rrat_map[3]=32, free_pd=34.
- Flush: dequeue 32..35, commit rd=1 pd=32, then flush -> free_count=32, free_pd=33, rrat_map[1]=32, register 1 present in the list at slot 0.
- Flush with same-cycle commit rd=2 pd=33 (after dequeuing 32,33 and committing rd=1 pd=32) -> rrat_map[2]=33 visible that cycle; next cycle free_count=32, free_pd=34.
- Commit rd=0, any pd -> no change to rrat_map, free_count or pointers.
